// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small byte FIFO at the CPU character-output port.
// Bytes go out LSB first. w_busy reports a full FIFO, and any write made while it is high is dropped.
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       w_req,
  input  logic [7:0] w_data,
  output logic       w_busy,
  output logic       uart_tx,
  output logic       tx_idle
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t            state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic              accept;
  logic              pop;
  logic              baud_end;
  logic              to_idle;
  logic [CNT_W-1:0]  count_next;
  logic [7:0]        head;

  // Handshake, pop decision and next occupancy, shared by the FIFO and the FSM
  always_comb begin
    accept     = w_req && !w_busy;
    baud_end   = (baud_cnt == BAUD_LAST);
    head       = mem[rd_ptr];
    pop        = 1'b0;
    to_idle    = 1'b0;
    count_next = count;
    case (state)
      IDLE: begin
        pop     = (count != '0);
        to_idle = (count == '0);
      end
      STOP: begin
        if (baud_end) begin
          pop     = (count != '0);
          to_idle = (count == '0);
        end
      end
      default: begin
      end
    endcase
    if (accept && !pop) begin
      count_next = count + CNT_W'(1);
    end else if (!accept && pop) begin
      count_next = count - CNT_W'(1);
    end
  end

  // Byte storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= w_data;
    end
  end

  // Pointers wrap naturally; occupancy alone tells full from empty
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      w_busy <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count  <= count_next;
      w_busy <= (count_next == FULL_CNT);
    end
  end

  // Framing FSM; uart_tx is loaded with the level of the state being entered
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      uart_tx  <= 1'b1;
      tx_idle  <= 1'b1;
    end else begin
      tx_idle <= to_idle && (count_next == '0);
      case (state)
        IDLE: begin
          uart_tx <= 1'b1;
          if (pop) begin
            shift    <= head;
            baud_cnt <= '0;
            state    <= START;
            uart_tx  <= 1'b0;
          end
        end
        START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
            uart_tx  <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            shift    <= {1'b0, shift[7:1]};
            bit_idx  <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state   <= STOP;
              uart_tx <= 1'b1;
            end else begin
              uart_tx <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (pop) begin
              shift   <= head;
              state   <= START;
              uart_tx <= 1'b0;
            end else begin
              state   <= IDLE;
              uart_tx <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          uart_tx <= 1'b1;
        end
      endcase
    end
  end

endmodule
